// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-port drain engine with 2-entry valid/ready output buffer
// Optional feature macro: FIFO_RD_STATS_EN (adds beat_total accepted-beat counter port)
module fifo_stream_reader #(
  parameter type DTYPE     = logic [7:0],
  parameter int  BURST_LEN = 16,
  parameter int  CNT_W     = ($clog2(BURST_LEN) > 0) ? $clog2(BURST_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic             fifo_ren,
  input  DTYPE             fifo_rdata,
  input  logic             fifo_empty,
  output logic             m_valid,
  output DTYPE             m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] burst_cnt
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]      beat_total
`endif
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]       r_occ;
  logic             r_head;
  logic             r_tail;
  DTYPE             r_data [2];
  logic             r_last [2];
  logic [CNT_W-1:0] r_cnt;

  logic             w_push;
  logic             w_accept;
  logic             w_beat_last;
  logic [CNT_W-1:0] w_cnt_next;

  // Pop only from registered occupancy so m_ready never reaches fifo_ren combinationally;
  // rst_n gating keeps the strobe low while reset is held.
  assign w_push      = rst_n && en && !clear && !fifo_empty && (r_occ != 2'd2);
  assign w_accept    = m_valid && m_ready && !clear;
  assign w_beat_last = (r_cnt == LAST_BEAT);
  assign w_cnt_next  = w_beat_last ? '0 : r_cnt + 1'b1;

  assign fifo_ren  = w_push;
  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_data[r_head];
  assign m_last    = r_last[r_head];
  assign burst_cnt = r_cnt;

  // Buffer entries: capture FIFO head word and its burst-end tag at the tail on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_data[r_tail] <= fifo_rdata;
      r_last[r_tail] <= w_beat_last;
    end
  end

  // Pointers, occupancy and beat counter; clear wins over push and accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_occ  <= 2'd0;
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= ~r_tail;
        r_cnt  <= w_cnt_next;
      end
      if (w_accept) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_accept})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] r_beat_total;

  assign beat_total = r_beat_total;

  // Saturating count of beats accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_total <= '0;
    end else if (clear) begin
      r_beat_total <= '0;
    end else if (w_accept && (r_beat_total != 32'hFFFF_FFFF)) begin
      r_beat_total <= r_beat_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader with BURST_LEN=4
module tb_fifo_stream_reader;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic       m_ready = 1'b0;
  logic       fifo_ren;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] burst_cnt;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] beat_total;
`endif

  fifo_stream_reader #(
    .DTYPE     (logic [7:0]),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .en         (en),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .burst_cnt  (burst_cnt)
`ifdef FIFO_RD_STATS_EN
    ,
    .beat_total (beat_total)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pop_cnt = 0;
  int         acc_cnt = 0;
  int         last_cnt = 0;
  int         beat_idx = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] sb [$];

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[8'(rd_ptr)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source FIFO model; flushed together with the DUT on clear or reset.
  always @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_ren) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Output monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !clear && m_valid && m_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (m_last) last_cnt <= last_cnt + 1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("m_data", 32'(m_data), 32'(e[7:0]));
        chk("m_last", 32'(m_last), 32'(e[8]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    logic is_last;
    is_last = ((beat_idx % BL) == BL - 1);
    mem[8'(wr_ptr)] = d;
    wr_ptr = wr_ptr + 1;
    sb.push_back({is_last, d});
    beat_idx++;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || rd_ptr != wr_ptr) && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_clear;
    clear = 1'b1;
    #1;
    chk("clr_ren", 32'(fifo_ren), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    sb.delete();
    beat_idx = 0;
  endtask

  initial begin
    int p0;
    int a0;
    int l0;
    int k;

    #2;
    chk("rst_ren", 32'(fifo_ren), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_cnt", 32'(burst_cnt), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Three words, consecutive output, one-cycle latency
    put(8'hA1); put(8'hB2); put(8'hC3);
    l0 = last_cnt;
    en = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("t1_ren", 32'(fifo_ren), 32'd1);
    chk("t1_valid0", 32'(m_valid), 32'd0);
    tick();
    chk("t1_valid1", 32'(m_valid), 32'd1);
    chk("t1_first", 32'(m_data), 32'hA1);
    tick();
    chk("t1_second", 32'(m_data), 32'hB2);
    wait_drain("t1_drain");
    chk("t1_lasts", 32'(last_cnt - l0), 32'd0);

    // Nine words with BURST_LEN=4
    do_clear();
    l0 = last_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 9; i++) put(8'(8'h10 + i));
    k = 0;
    while ((pop_cnt - p0) < 9 && k < 50) begin
      tick();
      k++;
    end
    chk("t2_pops", 32'(pop_cnt - p0), 32'd9);
    chk("t2_cnt", 32'(burst_cnt), 32'd1);
    wait_drain("t2_drain");
    chk("t2_lasts", 32'(last_cnt - l0), 32'd2);

    // Backpressure: two pops fill the buffer, then full-rate drain
    do_clear();
    m_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) put(8'(8'hC0 + i));
    repeat (6) tick();
    chk("t3_pops", 32'(pop_cnt - p0), 32'd2);
    chk("t3_ren", 32'(fifo_ren), 32'd0);
    chk("t3_valid", 32'(m_valid), 32'd1);
    chk("t3_hold", 32'(m_data), 32'hC0);
    a0 = acc_cnt;
    m_ready = 1'b1;
    repeat (5) tick();
    chk("t3_rate", 32'(acc_cnt - a0), 32'd5);
    wait_drain("t3_drain");

    // en dropped mid-burst, burst position resumes
    do_clear();
    l0 = last_cnt;
    put(8'h41); put(8'h42);
    wait_drain("t4_drain_a");
    en = 1'b0;
    put(8'h43); put(8'h44);
    repeat (3) tick();
    chk("t4_ren_off", 32'(fifo_ren), 32'd0);
    chk("t4_cnt_hold", 32'(burst_cnt), 32'd2);
    chk("t4_valid_off", 32'(m_valid), 32'd0);
    en = 1'b1;
    wait_drain("t4_drain_b");
    chk("t4_lasts", 32'(last_cnt - l0), 32'd1);

    // clear with a full buffer and burst_cnt=3
    do_clear();
    put(8'h51);
    wait_drain("t5_drain");
    m_ready = 1'b0;
    put(8'h52); put(8'h53); put(8'h54);
    repeat (4) tick();
    chk("t5_cnt3", 32'(burst_cnt), 32'd3);
    chk("t5_full_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    do_clear();
    chk("t5_valid_clr", 32'(m_valid), 32'd0);
    chk("t5_cnt_clr", 32'(burst_cnt), 32'd0);

    // Async reset mid-stream
    for (int i = 0; i < 4; i++) put(8'(8'h60 + i));
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_ren", 32'(fifo_ren), 32'd0);
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_data", 32'(m_data), 32'd0);
    chk("t6_last", 32'(m_last), 32'd0);
    chk("t6_cnt", 32'(burst_cnt), 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("t6_total_rst", beat_total, 32'd0);
`endif
    @(posedge clk);
    #1;
    sb.delete();
    beat_idx = 0;
    tick();
    rst_n = 1'b1;
    a0 = acc_cnt;
    put(8'h71); put(8'h72); put(8'h73);
    wait_drain("t6_drain");
    chk("t6_accepts", 32'(acc_cnt - a0), 32'd3);
`ifdef FIFO_RD_STATS_EN
    chk("t6_total", beat_total, 32'd3);
`endif

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
